// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link. The tx-side mux and this rx-side
// demux both import this package, so they agree on the slot count and on
// which slot carries the frame-sync flag.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

    // Frame sync is carried on slot 0.
    localparam logic [SLOT_W-1:0] SYNC_SLOT = '0;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // True when a beat at this slot index is expected to carry in_sync=1.
    function automatic logic is_sync_slot(input logic [SLOT_W-1:0] s);
        return s == SYNC_SLOT;
    endfunction

endpackage

// File: rtl/tdm_demux4.sv
// Receive-side 4:1 TDM demultiplexer.
// Aligns to the slot-0 frame sync, deserializes four W-bit slots into a
// registered 4*W word and reports alignment errors.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  beat qualifier for in_data / in_sync
//   in_data   slot sample (W bits)
//   in_sync   high on the beat carrying slot 0
//   out_data  assembled frame, slot k at [k*W +: W]
//   out_valid one-cycle pulse when out_data has just updated
//   locked    high while frame-aligned
//   slot      index of the next expected slot
//   sync_err  one-cycle pulse on an alignment error
//   err_cnt   saturating sync-error count
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W     = 8,
    parameter int ERR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    input  logic                   in_sync,
    output logic [NUM_SLOTS*W-1:0] out_data,
    output logic                   out_valid,
    output logic                   locked,
    output logic [SLOT_W-1:0]      slot,
    output logic                   sync_err,
    output logic [ERR_W-1:0]       err_cnt
);

    state_t state, next_state;

    // Slots 0..2 are staged; slot 3 goes straight into out_data together
    // with the staged slots so out_data never shows a partial frame.
    logic [NUM_SLOTS-2:0][W-1:0] staging;

    logic take;     // in-order beat: store at current slot
    logic restart;  // beat starts a new frame as slot 0
    logic err;      // alignment error on this beat

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= next_state;
    end

    // Next-state and beat classification
    always_comb begin
        next_state = state;
        take       = 1'b0;
        restart    = 1'b0;
        err        = 1'b0;
        if (in_valid) begin
            unique case (state)
                HUNT: begin
                    // Non-sync beats are dropped quietly while hunting.
                    if (in_sync) begin
                        restart    = 1'b1;
                        next_state = LOCKED;
                    end
                end
                LOCKED: begin
                    if (in_sync == is_sync_slot(slot)) begin
                        take = 1'b1;
                    end else if (in_sync) begin
                        // Early sync: resynchronize on this beat, stay locked.
                        err     = 1'b1;
                        restart = 1'b1;
                    end else begin
                        // Missing sync: alignment lost, drop the beat.
                        err        = 1'b1;
                        next_state = HUNT;
                    end
                end
                default: next_state = HUNT;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        locked = (state == LOCKED);
    end

    // Slot counter, staging, output word and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            staging   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            sync_err  <= err;

            if (err && (err_cnt != {ERR_W{1'b1}}))
                err_cnt <= err_cnt + 1'b1;

            if (restart) begin
                staging[0] <= in_data;
                slot       <= SLOT_W'(1);
            end else if (take) begin
                slot <= slot + 1'b1;
                unique case (slot)
                    2'd0: staging[0] <= in_data;
                    2'd1: staging[1] <= in_data;
                    2'd2: staging[2] <= in_data;
                    default: begin
                        out_data  <= {in_data, staging};
                        out_valid <= 1'b1;
                    end
                endcase
            end else if (err) begin
                slot <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sync = 1'b0;
    logic [7:0]  in_data = '0;

    logic [31:0] out_data, out_data2;
    logic        out_valid, out_valid2;
    logic        locked, locked2;
    logic [1:0]  slot, slot2;
    logic        sync_err, sync_err2;
    logic [7:0]  err_cnt;
    logic [1:0]  err_cnt2;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    logic [31:0] exp_frames[$];
    int          exp_errs[$];

    always #5 clk = ~clk;

    tdm_demux4 #(.W(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .out_data(out_data), .out_valid(out_valid),
        .locked(locked), .slot(slot), .sync_err(sync_err), .err_cnt(err_cnt)
    );

    // Narrow error counter copy, driven identically, for saturation checks.
    tdm_demux4 #(.W(8), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sync(in_sync), .out_data(out_data2), .out_valid(out_valid2),
        .locked(locked2), .slot(slot2), .sync_err(sync_err2), .err_cnt(err_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat(input logic s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3, input int gap);
        exp_frames.push_back({d3, d2, d1, d0});
        beat(1'b1, d0); if (gap > 0) idle(gap);
        beat(1'b0, d1); if (gap > 0) idle(gap);
        beat(1'b0, d2); if (gap > 0) idle(gap);
        beat(1'b0, d3);
    endtask

    task automatic expect_err();
        ecnt++;
        exp_errs.push_back(ecnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        ecnt = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a frame or error.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid || sync_err)
                chk("valid_err_exclusive", {31'b0, out_valid & sync_err}, 32'd0);
            if (out_valid) begin
                if (exp_frames.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", out_data);
                end else begin
                    chk("frame", out_data, exp_frames.pop_front());
                end
            end
            if (sync_err) begin
                if (exp_errs.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_sync_err: got err_cnt %0d expected no error", err_cnt);
                end else begin
                    int e;
                    e = exp_errs.pop_front();
                    chk("err_cnt", {24'b0, err_cnt}, e);
                    chk("err_cnt_sat", {30'b0, err_cnt2}, (e > 3) ? 3 : e);
                    chk("sync_err_sat_pulse", {31'b0, sync_err2}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_locked", {31'b0, locked}, 32'd0);
        chk("rst_slot", {30'b0, slot}, 32'd0);
        chk("rst_sync_err", {31'b0, sync_err}, 32'd0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Clean frame
        frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        chk("t1_locked", {31'b0, locked}, 32'd1);
        chk("t1_err_cnt", {24'b0, err_cnt}, 32'd0);
        chk("t1_out_valid", {31'b0, out_valid}, 32'd1);
        idle(1);
        chk("t1_out_valid_pulse", {31'b0, out_valid}, 32'd0);
        chk("t1_out_data_hold", out_data, 32'h44332211);

        // HUNT discard plus gaps
        do_reset();
        rst = 1'b0;
        beat(1'b0, 8'hAA);
        beat(1'b0, 8'hBB);
        chk("t2_hunt_locked", {31'b0, locked}, 32'd0);
        frame(8'h11, 8'h22, 8'h33, 8'h44, 3);
        idle(1);

        // Early sync
        exp_frames.push_back(32'h40302010);
        beat(1'b1, 8'h01);
        beat(1'b0, 8'h02);
        expect_err();
        beat(1'b1, 8'h10);
        chk("t3_slot_after_resync", {30'b0, slot}, 32'd1);
        chk("t3_locked", {31'b0, locked}, 32'd1);
        beat(1'b0, 8'h20);
        beat(1'b0, 8'h30);
        beat(1'b0, 8'h40);
        idle(1);

        // Missing sync, then relock
        expect_err();
        beat(1'b0, 8'h55);
        chk("t4_unlocked", {31'b0, locked}, 32'd0);
        chk("t4_slot", {30'b0, slot}, 32'd0);
        frame(8'h66, 8'h77, 8'h88, 8'h99, 0);
        chk("t4_relocked", {31'b0, locked}, 32'd1);
        idle(1);

        // Saturation: five more missing-sync errors, each followed by a relock
        for (int i = 0; i < 5; i++) begin
            expect_err();
            beat(1'b0, 8'hEE);
            frame(8'(i*16+1), 8'(i*16+2), 8'(i*16+3), 8'(i*16+4), 0);
        end
        idle(1);
        chk("t5_err_cnt_wide", {24'b0, err_cnt}, 32'd7);
        chk("t5_err_cnt_sat", {30'b0, err_cnt2}, 32'd3);

        // Reset mid-frame
        beat(1'b1, 8'hA1);
        beat(1'b0, 8'hA2);
        chk("t6_slot_mid", {30'b0, slot}, 32'd2);
        do_reset();
        chk("t6_out_data", out_data, 32'h0);
        chk("t6_out_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_locked", {31'b0, locked}, 32'd0);
        chk("t6_slot", {30'b0, slot}, 32'd0);
        chk("t6_err_cnt", {24'b0, err_cnt}, 32'd0);
        chk("t6_err_cnt_sat", {30'b0, err_cnt2}, 32'd0);
        rst = 1'b0;
        frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1);
        idle(4);
        chk("t6_out_data_final", out_data, 32'hC3C2C1C0);

        chk("frames_outstanding", exp_frames.size(), 32'd0);
        chk("errors_outstanding", exp_errs.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4:1 time-division mux path. A single W-bit sample stream arrives one slot per valid beat, with a frame-sync flag on slot 0.
- The block aligns to frames, deserializes four slots into a registered parallel word, and reports sync errors.
- It sits after the serial link and feeds downstream per-channel consumers.

Parameters:
- W, 8, bits per slot sample
- ERR_W, 8, width of the saturating sync-error counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  beat qualifier for in_data and in_sync
- in_data  input  W  slot sample
- in_sync  input  1  high on the beat carrying slot 0
- out_data  output  4*W  assembled frame; slot k at bits [k*W +: W]
- out_valid  output  1  one-cycle pulse when out_data has just updated
- locked  output  1  high while in LOCKED
- slot  output  2  index of the next expected slot
- sync_err  output  1  one-cycle pulse on any alignment error
- err_cnt  output  ERR_W  count of sync errors; saturates at all-ones

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=HUNT, slot=0, staging registers=0.
  - All outputs 0.
  - Reset wins over any same-cycle beat. Reset mid-frame discards the partial frame.
- Beats: only cycles with in_valid=1 act. With in_valid=0, all state holds, and gaps of any length are legal.
- HUNT:
  - Beats with in_sync=0 are discarded silently; no sync_err is raised.
  - A beat with in_sync=1 stores in_data into staging[0], sets slot=1 and moves to LOCKED.
  - locked=1 from the cycle after that beat.
- LOCKED, normal beat (in_sync==(slot==0)):
  - Store in_data into staging[slot], then slot <= slot+1 (wraps 3->0).
  - When slot==3: out_data <= {in_data, staging[2], staging[1], staging[0]} and out_valid=1 on the next cycle.
  - Latency: slot-3 beat at edge N gives out_data/out_valid visible after edge N.
- LOCKED, early sync (in_sync=1, slot!=0):
  - sync_err pulse; err_cnt increments.
  - The partial frame is discarded and out_data is unchanged.
  - The beat is taken as the new slot 0: staging[0]<=in_data, slot=1, stay LOCKED.
- LOCKED, missing sync (in_sync=0, slot==0):
  - sync_err pulse; err_cnt increments.
  - The beat is discarded; go to HUNT, slot=0, locked=0.
- err_cnt saturates at 2^ERR_W-1. sync_err still pulses while saturated.
- out_data holds its value between frames. It is never partially updated.
- out_valid and sync_err are never both high in the same cycle.
- Expected size: one 2-state FSM, a 2-bit slot counter, 3 staging registers, the output register and the error counter, about 150 lines.

Decomposition:
- Shared package tdm_pkg:
  - NUM_SLOTS=4, SLOT_W=2.
  - Enum state_t {HUNT, LOCKED}.
  - Slot-0 sync convention, shared with the tx-side 4:1 mux so both ends agree.
- No sub-module. The slot counter is inline because it is trivial and tightly coupled to FSM error handling.

Test Plan:
- Reset then clean frame: beats (sync=1,0x11),(0,0x22),(0,0x33),(0,0x44) -> one cycle after the 4th beat, out_data=0x44332211, out_valid=1 for exactly 1 cycle, locked=1, err_cnt=0.
- HUNT discard plus gaps: beats 0xAA,0xBB with sync=0, then the frame from test 1 with 3 idle cycles between beats -> no sync_err; same out_data, 0x44332211.
- Early sync: after a locked frame, send (1,0x01),(0,0x02),(1,0x10),(0,0x20),(0,0x30),(0,0x40).
  - sync_err pulses on the 3rd beat; err_cnt=1.
  - out_data=0x40302010; 0x01/0x02 never appear.
- Missing sync: while locked at slot=0, send (0,0x55) -> sync_err, err_cnt+1, locked=0 next cycle; a following (1,0x66) relocks.
- Saturation with ERR_W=2: force 5 missing-sync errors -> err_cnt stops at 3, and sync_err pulses all 5 times.
- Reset mid-frame: after slots 0-1, assert rst for 1 cycle -> outputs 0 and HUNT. A new full frame then yields exactly that frame, with no stale staging data.
